// File: rtl/ddr3_status_pkg.sv
// Purpose: shared types and constants for the DDR3 bring-up status monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: bring-up state enum and bit positions within the 4-bit status word.
package ddr3_status_pkg;

    typedef enum logic [1:0] {
        WAIT_PLL = 2'd0,
        WAIT_CAL = 2'd1,
        READY    = 2'd2,
        FAULT    = 2'd3
    } ddr3_mon_state_t;

    localparam int STAT_INIT     = 0;
    localparam int STAT_CAL_OK   = 1;
    localparam int STAT_CAL_FAIL = 2;
    localparam int STAT_TIMEOUT  = 3;

endpackage

// File: rtl/status_sync_filter.sv
// Purpose: synchronise one asynchronous flag and deglitch it with a stability counter.
// Latency: SYNC_STAGES + STABLE_CYCLES cycles from a held raw edge to d_filt.
// Backpressure: none; free-running, one sample per clock.
// Ports: clk_clk/reset_reset (sync, active-high), d_in raw async flag, d_filt filtered flag.
module status_sync_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic d_in,
    output logic d_filt
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    // The counter value seen on the cycle that completes a stable run.
    localparam logic [CW-1:0] RUN_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          run_cnt;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_q  <= '0;
            run_cnt <= '0;
            d_filt  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
            // Any sample agreeing with the current output breaks the run.
            if (sample == d_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == RUN_LAST) begin
                d_filt  <= sample;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ddr3_status_monitor.sv
// Purpose: supervise DDR3 EMIF bring-up and drive the 4-bit status PIO, ready and heartbeat LED.
// Latency: raw flag to state/ready/sticky = SYNC_STAGES + STABLE_CYCLES + 1 cycles; all outputs registered.
// Backpressure: none; clear_sticky is a one-cycle request honoured only in FAULT.
// Ports: clk_clk, reset_reset (sync, active-high); pll_locked_in, init_done_in, cal_success_in,
//        cal_fail_in (async EMIF flags); clear_sticky; status[3:0], state[1:0], ready, heartbeat.
module ddr3_status_monitor
    import ddr3_status_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int HB_CYCLES      = 25000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       pll_locked_in,
    input  logic       init_done_in,
    input  logic       cal_success_in,
    input  logic       cal_fail_in,
    input  logic       clear_sticky,
    output logic [3:0] status,
    output logic [1:0] state,
    output logic       ready,
    output logic       heartbeat
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int HW = $clog2(HB_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HB_LAST = HW'(HB_CYCLES - 1);

    logic pll_f, init_f, cal_ok_f, cal_fail_f;

    ddr3_mon_state_t st;
    logic [TW-1:0]   to_cnt;
    logic [HW-1:0]   hb_cnt;
    logic            cal_fail_stk;
    logic            timeout_stk;

    status_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_pll (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .d_in(pll_locked_in), .d_filt(pll_f));
    status_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_init (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .d_in(init_done_in), .d_filt(init_f));
    status_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_cal_ok (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .d_in(cal_success_in), .d_filt(cal_ok_f));
    status_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_cal_fail (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .d_in(cal_fail_in), .d_filt(cal_fail_f));

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            st           <= WAIT_PLL;
            ready        <= 1'b0;
            to_cnt       <= '0;
            hb_cnt       <= '0;
            heartbeat    <= 1'b0;
            cal_fail_stk <= 1'b0;
            timeout_stk  <= 1'b0;
        end else begin
            case (st)
                WAIT_PLL: begin
                    if (pll_f) begin
                        st     <= WAIT_CAL;
                        to_cnt <= '0;
                    end
                end
                WAIT_CAL: begin
                    // Row order is priority: a reported failure beats a simultaneous success.
                    if (cal_fail_f) begin
                        st           <= FAULT;
                        cal_fail_stk <= 1'b1;
                    end else if (!pll_f) begin
                        st <= WAIT_PLL;
                    end else if (init_f && cal_ok_f) begin
                        st     <= READY;
                        ready  <= 1'b1;
                        hb_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        st          <= FAULT;
                        timeout_stk <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                READY: begin
                    if (cal_fail_f || !pll_f || !cal_ok_f || !init_f) begin
                        // Lost lock/init/cal is a fault but leaves no sticky trace.
                        st           <= FAULT;
                        ready        <= 1'b0;
                        hb_cnt       <= '0;
                        heartbeat    <= 1'b0;
                        cal_fail_stk <= cal_fail_stk | cal_fail_f;
                    end else if (hb_cnt == HB_LAST) begin
                        hb_cnt    <= '0;
                        heartbeat <= ~heartbeat;
                    end else begin
                        hb_cnt <= hb_cnt + HW'(1);
                    end
                end
                FAULT: begin
                    // Clearing wins; a fault that persists is found again on the way back up.
                    if (clear_sticky) begin
                        st           <= WAIT_PLL;
                        cal_fail_stk <= 1'b0;
                        timeout_stk  <= 1'b0;
                        to_cnt       <= '0;
                        hb_cnt       <= '0;
                        heartbeat    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign state = st;

    always_comb begin
        status                = '0;
        status[STAT_INIT]     = init_f;
        status[STAT_CAL_OK]   = cal_ok_f;
        status[STAT_CAL_FAIL] = cal_fail_stk;
        status[STAT_TIMEOUT]  = timeout_stk;
    end

endmodule

// File: doc/ddr3_status_monitor.md
# ddr3_status_monitor

Supervises DDR3 EMIF bring-up and feeds the 4-bit `ddr3_status` PIO input of the Nios system, sitting directly upstream of that PIO. It synchronises and deglitches the EMIF PLL-lock and calibration/status flags and runs a bring-up state machine with a calibration timeout. It produces sticky fault bits for software, a `ready` qualifier, and a heartbeat for a board LED.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops per raw input (≥2).
- `STABLE_CYCLES`, 4: consecutive equal synced samples required before a filtered flag changes (≥1).
- `TIMEOUT_CYCLES`, 1000000: cycles allowed in WAIT_CAL before a timeout fault (≥2).
- `HB_CYCLES`, 25000000: heartbeat half-period in READY (≥2).

Ports:
- `clk_clk`  in  1  system clock; single clock domain.
- `reset_reset`  in  1  synchronous, active-high reset.
- `pll_locked_in`  in  1  EMIF PLL locked; asynchronous.
- `init_done_in`  in  1  EMIF `local_init_done`; asynchronous.
- `cal_success_in`  in  1  EMIF `local_cal_success`; asynchronous.
- `cal_fail_in`  in  1  EMIF `local_cal_fail`; asynchronous.
- `clear_sticky`  in  1  synchronous, one-cycle request from a key or PIO; honoured only in FAULT.
- `status`  out  4  to PIO: [0] filtered init_done, [1] filtered cal_success, [2] cal_fail sticky, [3] timeout sticky.
- `state`  out  2  WAIT_PLL=0, WAIT_CAL=1, READY=2, FAULT=3.
- `ready`  out  1  high iff state==READY.
- `heartbeat`  out  1  toggles in READY, 0 otherwise.

## Operation
- Each raw input passes through a SYNC_STAGES flop chain, then a stability filter.
  - The filter has a counter of width $clog2(STABLE_CYCLES+1).
  - Counter clears whenever the synced sample equals the current filtered value.
  - Otherwise it increments; when it reaches STABLE_CYCLES, the filtered value takes the sample and the counter clears.
- FSM transitions. Within a state, the first matching row wins.
  - WAIT_PLL: pll_f=1 → WAIT_CAL, with the timeout counter cleared.
  - WAIT_CAL:
    - cal_fail_f=1 → FAULT, set status[2].
    - pll_f=0 → WAIT_PLL.
    - init_done_f & cal_success_f → READY.
    - Timeout counter == TIMEOUT_CYCLES-1 → FAULT, set status[3].
    - Otherwise the counter increments.
  - READY:
    - cal_fail_f=1 → FAULT, set status[2].
    - pll_f=0, or cal_success_f=0, or init_done_f=0 → FAULT, with no sticky bit set.
  - FAULT: clear_sticky=1 → WAIT_PLL; status[3:2] cleared, timeout and heartbeat counters cleared. Otherwise hold.
- cal_fail beats cal_success when both are filtered high in the same cycle.
- clear_sticky outside FAULT is ignored. In FAULT it wins over any simultaneous fault condition; a persisting fault is re-detected through WAIT_PLL/WAIT_CAL.
- Sticky bits set only on the FAULT-entry cycle and clear only via clear_sticky in FAULT, or via reset.
- Heartbeat counter (width $clog2(HB_CYCLES)) runs only in READY. At HB_CYCLES-1 it wraps to 0 and toggles `heartbeat`. On leaving READY, counter and `heartbeat` are forced to 0.
- status[1:0] come directly from the filtered registers, independent of state.

## Timing
- Reset (synchronous, wins over all inputs):
  - all sync flops, filtered flags and counters = 0;
  - state=WAIT_PLL;
  - status=4'b0000, ready=0, heartbeat=0.
- Raw edge to filtered flag: SYNC_STAGES+STABLE_CYCLES cycles, provided the input holds.
- A glitch shorter than STABLE_CYCLES synced cycles never reaches the filtered flag.
- The FSM samples filtered flags, so `state`/`ready`/sticky bits update 1 cycle after the filtered flag changes.
- Timeout: FAULT registered exactly TIMEOUT_CYCLES cycles after WAIT_CAL entry, if READY is not reached.
- Heartbeat: first toggle HB_CYCLES cycles after READY entry, then every HB_CYCLES.
- Reset mid-operation returns to the reset values on the next edge; sticky history is lost.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `ddr3_status_pkg` holds:
  - state enum `ddr3_mon_state_t` (2 bits, encodings above);
  - status bit index constants STAT_INIT=0, STAT_CAL_OK=1, STAT_CAL_FAIL=2, STAT_TIMEOUT=3.
- Sub-module `status_sync_filter` (params SYNC_STAGES, STABLE_CYCLES; ports clk_clk, reset_reset, d_in, d_filt), instantiated 4×.
- Top holds the FSM, timeout counter, heartbeat counter and sticky register.

## Test plan
All scenarios use SYNC_STAGES=2, STABLE_CYCLES=4, TIMEOUT_CYCLES=100, HB_CYCLES=8.
- Normal bring-up: pll_locked high, then init_done and cal_success high 20 cycles later → state 0→1→2. `ready` rises 7 cycles after the flags, status=4'b0011, heartbeat toggles every 8 cycles.
- Glitch rejection: 3-cycle pulse on cal_fail_in while READY → status stays 4'b0011, state stays 2, no FAULT.
- Calibration failure: cal_fail and cal_success raised together in WAIT_CAL → FAULT with status[2]=1. clear_sticky pulse → state 0, status[3:2]=00.
- Timeout: pll_locked high, EMIF flags held low → FAULT exactly 100 cycles after WAIT_CAL entry, status=4'b1000, heartbeat=0.
- Lost lock in READY: pll_locked_in drops → state 3 after 7 cycles, no sticky bit set. clear_sticky with lock restored → re-runs to READY.
- Reset mid-operation: assert reset_reset for 1 cycle in READY, or in FAULT with status[3]=1 → next cycle state=0, status=0, ready=0, heartbeat=0.
